// File: rtl/uart_rcvr.sv
// 8-bit UART receiver, LSB first, mid-bit sampling, one stop bit.
// Define UART_RCVR_PARITY_EN to expect and check an even-parity bit.
`timescale 1ns/1ps
module uart_rcvr #(
  parameter int CLKS_PER_BIT = 55
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       framing_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_d;
  logic [1:0]      fill;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            fall;
  logic            at_half;
  logic            at_last;
  logic            cnt_clr;
  logic            shift_en;
  logic            done_ok;
  logic            done_fe;

  // rx_d stays 0 until the synchronizer holds real line samples,
  // so a line that is already low at reset release is not an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b0;
      fill    <= 2'b00;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_d    <= fill[1] & rx_s;
      fill    <= {fill[0], 1'b1};
    end
  end

  assign fall    = rx_d & ~rx_s;
  assign at_half = (cnt == HALF);
  assign at_last = (cnt == LAST);

`ifdef UART_RCVR_PARITY_EN
  logic par_en;
  logic par_bad;
  logic done_pe;
`endif

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    done_ok  = 1'b0;
    done_fe  = 1'b0;
`ifdef UART_RCVR_PARITY_EN
    par_en   = 1'b0;
    done_pe  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_n = START;
      end
      START: begin
        if (at_half) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RCVR_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (at_last) begin
          cnt_clr = 1'b1;
`ifdef UART_RCVR_PARITY_EN
          par_en  = 1'b1;
`endif
          state_n = STOP;
        end
      end
      STOP: begin
        if (at_last) begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            done_fe = 1'b1;
            state_n = WAIT_HIGH;
          end else begin
`ifdef UART_RCVR_PARITY_EN
            done_pe = par_bad;
            done_ok = ~par_bad;
`else
            done_ok = 1'b1;
`endif
            state_n = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Counter saturates so it never wraps inside a long state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (!at_last) cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else if (state == START) begin
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      shreg[bit_cnt] <= rx_s;
      bit_cnt        <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uart_data       <= 8'h00;
      uart_data_valid <= 1'b0;
      framing_err     <= 1'b0;
    end else begin
      uart_data_valid <= done_ok;
      framing_err     <= done_fe;
      if (done_ok) uart_data <= shreg;
    end
  end

`ifdef UART_RCVR_PARITY_EN
  logic perr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= done_pe;
      if (state == START) par_bad <= 1'b0;
      else if (par_en)    par_bad <= ^{shreg, rx_s};
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
